// File: rtl/reconfig_bf_pixel_core.sv
// Per-pixel beamforming core: DAS (sum) or DMAS (pairwise products of signed square roots).
// Optional BF_SAT_EN: clamp the result to the OUT_W signed range instead of wrapping it.
module reconfig_bf_pixel_core #(
    parameter int NUM_CH = 128,
    parameter int DATA_W = 16,
    parameter int OUT_W  = 32,
    parameter int CH_W   = $clog2(NUM_CH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [CH_W-1:0]   n_ch,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [OUT_W-1:0]  bf_out,
    output logic              busy
);
    localparam int H        = DATA_W / 2;
    localparam int H2       = 2 * H;
    localparam int Y_W      = H + 1;
    localparam int SQRT_LAT = H;
    localparam int R_W      = H + 5;
    localparam int SW       = Y_W + CH_W;
    localparam int QW       = 2 * Y_W + CH_W;
    localparam int PW       = 2 * SW;
    localparam int AW       = DATA_W + CH_W;
    localparam int RES_W    = PW + 1;
    localparam int WW       = (RES_W > OUT_W) ? RES_W : OUT_W;
    localparam int FW       = $clog2(SQRT_LAT + 1);

    typedef enum logic [2:0] {S_IDLE, S_ACC, S_FLUSH, S_SQ, S_FIN, S_OUT} state_t;

    state_t state, state_nxt;
    logic [CH_W-1:0] ch, n_eff, n_ch_in, n_cur;
    logic [FW-1:0]   fcnt;
    logic            mode_r, mode_cur, accept, last;
    logic signed [AW-1:0] acc;
    logic signed [SW-1:0] s_acc;
    logic signed [QW-1:0] q_acc;
    logic signed [PW-1:0] p_r;

    logic [DATA_W-1:0]    pd [SQRT_LAT];
    logic signed [R_W-1:0] pr [SQRT_LAT];
    logic [H-1:0]         pq [SQRT_LAT];
    logic                 ps [SQRT_LAT];
    logic                 pv [SQRT_LAT];

    logic [DATA_W-1:0]    d_in [SQRT_LAT], d_nx [SQRT_LAT];
    logic signed [R_W-1:0] r_in [SQRT_LAT], r_nx [SQRT_LAT];
    logic [H-1:0]         q_in [SQRT_LAT], q_nx [SQRT_LAT];
    logic signed [R_W-1:0] r_sh;
    logic [DATA_W-1:0]    abs_x;
    logic signed [Y_W-1:0] y_last;
    logic [H2-1:0]        ysq;
    logic signed [WW-1:0] res_w, max_v, min_v;
    logic [OUT_W-1:0]     narrowed;
    logic                 unused_bits;

    always_comb begin
        in_ready = (state == S_IDLE) || (state == S_ACC);
        n_ch_in  = (n_ch == '0 || n_ch > CH_W'(NUM_CH)) ? CH_W'(NUM_CH) : n_ch;
        n_cur    = (state == S_IDLE) ? n_ch_in : n_eff;
        mode_cur = (state == S_IDLE) ? mode : mode_r;
        accept   = in_valid && in_ready;
        last     = accept && (ch == n_cur - CH_W'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (last)        state_nxt = mode ? S_FIN : S_FLUSH;
                else if (accept) state_nxt = S_ACC;
            end
            S_ACC:   if (last) state_nxt = mode_r ? S_FIN : S_FLUSH;
            S_FLUSH: if (fcnt == FW'(SQRT_LAT - 1)) state_nxt = S_SQ;
            S_SQ:    state_nxt = S_FIN;
            S_FIN:   state_nxt = S_OUT;
            S_OUT: begin
                out_valid = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Non-restoring square root, one result bit per stage; a negative partial
    // remainder is corrected in the next stage instead of being restored.
    always_comb begin
        abs_x   = in_data[DATA_W-1] ? (DATA_W'(0) - in_data) : in_data;
        r_sh    = '0;
        d_in[0] = abs_x;
        r_in[0] = '0;
        q_in[0] = '0;
        for (int unsigned i = 1; i < SQRT_LAT; i++) begin
            d_in[i] = pd[i-1];
            r_in[i] = pr[i-1];
            q_in[i] = pq[i-1];
        end
        for (int unsigned i = 0; i < SQRT_LAT; i++) begin
            r_sh = R_W'({r_in[i], d_in[i][DATA_W-1 -: 2]});
            if (r_in[i][R_W-1]) r_nx[i] = r_sh + R_W'({q_in[i], 2'b11});
            else                r_nx[i] = r_sh - R_W'({q_in[i], 2'b01});
            q_nx[i] = H'({q_in[i], ~r_nx[i][R_W-1]});
            d_nx[i] = d_in[i] << 2;
        end
        y_last = ps[SQRT_LAT-1] ? -$signed({1'b0, pq[SQRT_LAT-1]}) : $signed({1'b0, pq[SQRT_LAT-1]});
        ysq    = H2'(pq[SQRT_LAT-1]) * H2'(pq[SQRT_LAT-1]);
    end

    always_comb begin
        res_w = mode_r ? WW'(acc) : ((WW'(p_r) - WW'(q_acc)) >>> 1);
        max_v = '0;
        max_v[OUT_W-1:0] = {1'b0, {(OUT_W-1){1'b1}}};
        min_v = ~max_v;
`ifdef BF_SAT_EN
        if (res_w > max_v)      narrowed = max_v[OUT_W-1:0];
        else if (res_w < min_v) narrowed = min_v[OUT_W-1:0];
        else                    narrowed = res_w[OUT_W-1:0];
`else
        narrowed = res_w[OUT_W-1:0];
`endif
        unused_bits = ^{res_w, max_v, min_v, pd[SQRT_LAT-1], pr[SQRT_LAT-1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch     <= '0;
            n_eff  <= '0;
            mode_r <= 1'b0;
            fcnt   <= '0;
            acc    <= '0;
            s_acc  <= '0;
            q_acc  <= '0;
            p_r    <= '0;
            bf_out <= '0;
            for (int unsigned i = 0; i < SQRT_LAT; i++) begin
                pd[i] <= '0;
                pr[i] <= '0;
                pq[i] <= '0;
                ps[i] <= 1'b0;
                pv[i] <= 1'b0;
            end
        end else begin
            if (accept) begin
                ch  <= last ? '0 : ch + CH_W'(1);
                acc <= ((state == S_IDLE) ? '0 : acc) + AW'($signed(in_data));
            end
            if (accept && state == S_IDLE) begin
                mode_r <= mode;
                n_eff  <= n_ch_in;
                s_acc  <= '0;
                q_acc  <= '0;
            end else if (pv[SQRT_LAT-1]) begin
                s_acc <= s_acc + SW'(y_last);
                q_acc <= q_acc + QW'(ysq);
            end
            fcnt <= (state == S_FLUSH) ? fcnt + FW'(1) : '0;
            if (state == S_SQ)  p_r    <= PW'(s_acc) * PW'(s_acc);
            if (state == S_FIN) bf_out <= narrowed;
            for (int unsigned i = 0; i < SQRT_LAT; i++) begin
                pd[i] <= d_nx[i];
                pr[i] <= r_nx[i];
                pq[i] <= q_nx[i];
            end
            pv[0] <= accept && !mode_cur;
            ps[0] <= in_data[DATA_W-1];
            for (int unsigned i = 1; i < SQRT_LAT; i++) begin
                pv[i] <= pv[i-1];
                ps[i] <= ps[i-1];
            end
        end
    end
endmodule

// File: tb/tb_reconfig_bf_pixel_core.sv
// Randomized bench for reconfig_bf_pixel_core against a pairwise-product reference model;
// a second instance with OUT_W=8 checks result narrowing (BF_SAT_EN aware).
module tb_reconfig_bf_pixel_core;
    localparam int NUM_CH   = 128;
    localparam int DATA_W   = 16;
    localparam int CH_W     = 8;
    localparam int SQRT_LAT = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mode = 1'b0;
    logic [CH_W-1:0]   n_ch = '0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready, out_valid, busy;
    logic [31:0]       bf_out;
    logic              in_ready8, out_valid8, busy8;
    logic [7:0]        bf_out8;

    int n_checks = 0;
    int n_fail   = 0;
    int ov_count = 0;
    int pixels   = 0;
    int xs[$];

    reconfig_bf_pixel_core #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .OUT_W(32)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .n_ch(n_ch), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
        .bf_out(bf_out), .busy(busy)
    );

    reconfig_bf_pixel_core #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .OUT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .mode(mode), .n_ch(n_ch), .in_valid(in_valid),
        .in_ready(in_ready8), .in_data(in_data), .out_valid(out_valid8),
        .bf_out(bf_out8), .busy(busy8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (out_valid) ov_count++;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint isqrt(input longint a);
        longint q = 0;
        while ((q + 1) * (q + 1) <= a) q++;
        return q;
    endfunction

    function automatic longint model(input bit das, input int v[$]);
        longint y[$];
        longint r = 0;
        if (das) begin
            foreach (v[i]) r += v[i];
            return r;
        end
        foreach (v[i]) y.push_back(v[i] < 0 ? -isqrt(-longint'(v[i])) : isqrt(longint'(v[i])));
        for (int i = 0; i < y.size(); i++)
            for (int j = i + 1; j < y.size(); j++)
                r += y[i] * y[j];
        return r;
    endfunction

    function automatic longint narrow8(input longint v);
        byte b;
`ifdef BF_SAT_EN
        if (v > 127)  return 127;
        if (v < -128) return -128;
        return v;
`else
        b = byte'(v);
        return longint'(b);
`endif
    endfunction

    // Feeds xs as one pixel; mode/n_ch are randomized after the first sample to show they are ignored.
    task automatic run_pixel(input bit m, input int nport, input int gap, input bit hold);
        int     n_eff = (nport == 0 || nport > NUM_CH) ? NUM_CH : nport;
        longint exp   = model(m, xs);
        int     idx = 0, cyc = 0, k = 0;
        bit     done = 0, acc_now, offer;
        logic [31:0] held;
        pixels++;
        while (!done && cyc < 5000) begin
            offer    = (gap == 0) ? 1'b1 : ((cyc % (gap + 1)) == 0);
            in_valid = offer;
            in_data  = offer ? DATA_W'(xs[idx]) : DATA_W'($urandom);
            mode     = (idx == 0) ? m : 1'($urandom);
            n_ch     = (idx == 0) ? CH_W'(nport) : CH_W'($urandom);
            acc_now  = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc_now) begin
                idx++;
                if (idx == n_eff) done = 1;
            end
        end
        if (!done) begin
            check("accept_timeout", idx, n_eff);
            in_valid = 1'b0;
            return;
        end
        in_valid = hold;
        while (!out_valid && k < 40) begin
            check("rdy_low", in_ready, 0);
            in_data = DATA_W'($urandom);
            mode    = 1'($urandom);
            n_ch    = CH_W'($urandom);
            @(posedge clk); #1;
            k++;
        end
        check("ovalid_seen", out_valid, 1);
        check("latency", k, m ? 1 : SQRT_LAT + 2);
        check("bf_out", longint'($signed(bf_out)), exp);
        check("bf_out8", longint'($signed(bf_out8)), narrow8(exp));
        check("rdy_out", in_ready, 0);
        check("busy_out", busy, 1);
        held = bf_out;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("ovalid_pulse", out_valid, 0);
        check("rdy_after", in_ready, 1);
        check("busy_after", busy, 0);
        check("bf_hold", longint'(bf_out), longint'(held));
    endtask

    initial begin
        int nport, n_eff, ov_before;
        logic [15:0] r16;
        #2;
        check("rst_ready", in_ready, 1);
        check("rst_ovalid", out_valid, 0);
        check("rst_bf", longint'(bf_out), 0);
        check("rst_busy", busy, 0);
        #20 rst = 1'b0;
        @(posedge clk); #1;

        xs = '{100, -20, 30, 5};      run_pixel(1, 4, 0, 0);
        xs = '{16, -9, 4, 1};         run_pixel(0, 4, 0, 0);
        xs = '{17, -26};              run_pixel(0, 2, 0, 1);
        xs.delete(); repeat (128) xs.push_back(-32768);
        run_pixel(1, 0, 2, 0);
        run_pixel(0, 200, 0, 0);
        xs = '{100, 100, 100, 100};   run_pixel(1, 4, 0, 0);
        xs = '{-5};                   run_pixel(0, 1, 0, 0);
        xs = '{7};                    run_pixel(1, 1, 0, 1);
        xs = '{32767, 32767, 0};      run_pixel(0, 3, 1, 0);

        for (int p = 0; p < 12; p++) begin
            int sel = $urandom_range(0, 9);
            nport = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(129, 255) : $urandom_range(1, 24);
            n_eff = (nport == 0 || nport > NUM_CH) ? NUM_CH : nport;
            xs.delete();
            for (int i = 0; i < n_eff; i++) begin
                r16 = 16'($urandom);
                if ($urandom_range(0, 7) == 0) r16 = $urandom_range(0, 1) ? 16'h7fff : 16'h8000;
                xs.push_back(int'($signed(r16)));
            end
            run_pixel(1'($urandom), nport, $urandom_range(0, 2), 1'($urandom));
        end

        ov_before = ov_count;
        in_valid = 1'b1; mode = 1'b1; n_ch = 4;
        in_data = 16'd50; @(posedge clk); #1;
        in_data = 16'd60; @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_ovalid", out_valid, 0);
        check("midrst_bf", longint'(bf_out), 0);
        #3 rst = 1'b0;
        xs = '{1, 1, 1, 1};
        run_pixel(1, 4, 0, 0);
        check("midrst_pulses", ov_count - ov_before, 1);
        check("total_pulses", ov_count, pixels);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
